// File: rtl/mul_pkg.sv
// Shared mul-port codes (register file, decoder, multiplier) and the
// multiplier sequencer state encoding.
package mul_pkg;

    localparam logic [1:0] MUL_NONE = 2'd0;
    localparam logic [1:0] MUL_SET  = 2'd1;
    localparam logic [1:0] MUL_ACC  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIX   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/mul_shift_add_core.sv
// Unsigned shift-add datapath: one multiplier bit per step, with an optional
// two's-complement negate of the 2*WIDTH accumulator.
module mul_shift_add_core #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic                 clk,
    input  logic                 load,
    input  logic                 step,
    input  logic                 negate,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic                 count_done,
    output logic [2*WIDTH-1:0]   product_next
);

    localparam int CW = $clog2(ITER) + 1;
    localparam logic [2*WIDTH-1:0] ONE = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    always_comb begin
        acc_d = acc;
        if (load)
            acc_d = '0;
        else if (step && mplier[0])
            acc_d = acc + mcand;
        else if (negate)
            acc_d = ~acc + ONE;
    end

    // Datapath registers carry no reset; load initialises them.
    always_ff @(posedge clk) begin
        acc <= acc_d;
        if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            cnt    <= '0;
        end else if (step) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end
    end

    assign count_done   = (cnt == CW'(ITER - 1));
    assign product_next = acc_d;

endmodule

// File: rtl/hilo_mul_sequencer.sv
// Iterative hi/lo multiplier: sign-magnitude around an unsigned shift-add core,
// then a single registered write to the register file's hi/lo port.
module hilo_mul_sequencer
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic             rf_write_enable,
    output logic [1:0]       rf_mul,
    output logic [WIDTH-1:0] rf_write_data_1,
    output logic [WIDTH-1:0] rf_write_data_2
);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        // -2^(WIDTH-1) wraps to itself, which is the correct unsigned magnitude.
        return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    state_t             state, next_state;
    logic [1:0]         op_q;
    logic               neg_q;
    logic               accept;
    logic               count_done;
    logic [2*WIDTH-1:0] product_next;

    logic               busy_d, done_d, we_d;
    logic [1:0]         mul_d;
    logic [WIDTH-1:0]   data1_d, data2_d;

    assign accept = (state == S_IDLE) && start && !kill && (op == MUL_SET || op == MUL_ACC);

    mul_shift_add_core #(.WIDTH(WIDTH), .ITER(ITER)) u_core (
        .clk          (clk),
        .load         (accept),
        .step         (state == S_RUN),
        .negate       (state == S_FIX && neg_q && !kill),
        .a_mag        (magnitude(operand_a, signed_op)),
        .b_mag        (magnitude(operand_b, signed_op)),
        .count_done   (count_done),
        .product_next (product_next)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_RUN;
            S_RUN:   if (kill) next_state = S_IDLE;
                     else if (count_done) next_state = S_FIX;
            S_FIX:   next_state = kill ? S_IDLE : S_WRITE;
            S_WRITE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from next_state so the registered copies line up with the state.
    always_comb begin
        busy_d  = (next_state != S_IDLE);
        we_d    = (next_state == S_WRITE);
        done_d  = we_d;
        mul_d   = we_d ? op_q : MUL_NONE;
        data1_d = we_d ? product_next[WIDTH-1:0] : '0;
        data2_d = we_d ? product_next[2*WIDTH-1:WIDTH] : '0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= op;
            neg_q <= signed_op & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            rf_write_enable <= 1'b0;
            rf_mul          <= MUL_NONE;
            rf_write_data_1 <= '0;
            rf_write_data_2 <= '0;
        end else begin
            busy            <= busy_d;
            done            <= done_d;
            rf_write_enable <= we_d;
            rf_mul          <= mul_d;
            rf_write_data_1 <= data1_d;
            rf_write_data_2 <= data2_d;
        end
    end

endmodule
